// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST layer-2 datapath.
// Holds the operand widths, the feeder state encoding and the weight-row slice helper.
package mnist_pkg;

  localparam int DATA_W = 32;
  localparam int N_OUT  = 10;
  localparam int WROW_W = N_OUT * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_t;

  function automatic logic [DATA_W-1:0] wrow_slice(input logic [WROW_W-1:0] row, input int j);
    return row[j*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/feeder_operand_reg.sv
// Operand register for the layer-2 feeder: aligns memory read data with start/stop framing.
// Build option LAYER2_FEEDER_RELU_EN clamps negative activations to zero before registering.
module feeder_operand_reg
  import mnist_pkg::*;
#(
  parameter int N_HIDDEN = 32,
  parameter int AW       = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              abort,
  input  logic              rd_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] act_rdata,
  input  logic [WROW_W-1:0] wt_rdata,
  output logic [DATA_W-1:0] relu_out,
  output logic [WROW_W-1:0] wrow,
  output logic              start,
  output logic              stop
);

  localparam logic [AW-1:0] K_LAST = AW'(N_HIDDEN - 1);

  logic              valid_r;
  logic              first_r;
  logic              last_r;
  logic [DATA_W-1:0] act_s;

  // Optional rectification of the incoming activation word
  always_comb begin
    act_s = act_rdata;
`ifdef LAYER2_FEEDER_RELU_EN
    if (act_rdata[DATA_W-1]) begin
      act_s = '0;
    end else begin
      act_s = act_rdata;
    end
`endif
  end

  // Read-valid/first/last delay line and the operand register itself; zero outside the window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r  <= 1'b0;
      first_r  <= 1'b0;
      last_r   <= 1'b0;
      relu_out <= '0;
      wrow     <= '0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else if (abort) begin
      valid_r  <= 1'b0;
      first_r  <= 1'b0;
      last_r   <= 1'b0;
      relu_out <= '0;
      wrow     <= '0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      valid_r <= rd_en;
      first_r <= rd_en && (addr == '0);
      last_r  <= rd_en && (addr == K_LAST);
      if (valid_r) begin
        relu_out <= act_s;
        wrow     <= wt_rdata;
        start    <= first_r;
        stop     <= last_r;
      end else begin
        relu_out <= '0;
        wrow     <= '0;
        start    <= 1'b0;
        stop     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/layer2_feeder.sv
// Layer-2 operand sequencer: streams one hidden index per cycle into the ten layer-2 MACs.
// Build option LAYER2_FEEDER_RELU_EN enables activation clamping in feeder_operand_reg.
module layer2_feeder
  import mnist_pkg::*;
#(
  parameter int N_HIDDEN = 32,
  parameter int MAC_LAT  = 1,
  localparam int AW      = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [AW-1:0]     act_addr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic              wt_rd_en,
  output logic [AW-1:0]     wt_addr,
  input  logic [WROW_W-1:0] wt_rdata,
  output logic              start,
  output logic              stop,
  output logic [DATA_W-1:0] relu_out,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic [DATA_W-1:0] w9
);

  localparam int            CW         = $clog2(MAC_LAT + 2);
  localparam logic [AW-1:0] K_LAST     = AW'(N_HIDDEN - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(1);
  localparam logic [CW-1:0] DRAIN_LAST = (MAC_LAT > 0) ? CW'(MAC_LAT - 1) : '0;

  feeder_state_t     state_r, state_s;
  logic [AW-1:0]     k_r, k_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              busy_r;
  logic              done_r;
  logic              rd_en_r;
  logic [AW-1:0]     addr_r;
  logic [WROW_W-1:0] wrow_s;

  // Next-state, index counter and flush/drain counter
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        k_s   = '0;
        cnt_s = '0;
        if (go && !abort) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          state_s = ST_IDLE;
          k_s     = '0;
        end else if (k_r == K_LAST) begin
          state_s = ST_FLUSH;
          cnt_s   = '0;
        end else begin
          k_s = k_r + AW'(1);
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_s = ST_IDLE;
          k_s     = '0;
          cnt_s   = '0;
        end else if (cnt_r == FLUSH_LAST) begin
          cnt_s = '0;
          if (MAC_LAT == 0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_s = ST_IDLE;
          k_s     = '0;
          cnt_s   = '0;
        end else if (cnt_r == DRAIN_LAST) begin
          state_s = ST_DONE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        k_s     = '0;
        cnt_s   = '0;
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State register; status and read strobes are registered from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      rd_en_r <= (state_s == ST_STREAM);
      addr_r  <= (state_s == ST_STREAM) ? k_s : '0;
    end
  end

  feeder_operand_reg #(
    .N_HIDDEN (N_HIDDEN),
    .AW       (AW)
  ) u_operand_reg (
    .clk       (clk),
    .resetn    (resetn),
    .abort     (abort),
    .rd_en     (rd_en_r),
    .addr      (addr_r),
    .act_rdata (act_rdata),
    .wt_rdata  (wt_rdata),
    .relu_out  (relu_out),
    .wrow      (wrow_s),
    .start     (start),
    .stop      (stop)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign act_rd_en = rd_en_r;
  assign act_addr  = addr_r;
  assign wt_rd_en  = rd_en_r;
  assign wt_addr   = addr_r;

  assign w0 = wrow_slice(wrow_s, 0);
  assign w1 = wrow_slice(wrow_s, 1);
  assign w2 = wrow_slice(wrow_s, 2);
  assign w3 = wrow_slice(wrow_s, 3);
  assign w4 = wrow_slice(wrow_s, 4);
  assign w5 = wrow_slice(wrow_s, 5);
  assign w6 = wrow_slice(wrow_s, 6);
  assign w7 = wrow_slice(wrow_s, 7);
  assign w8 = wrow_slice(wrow_s, 8);
  assign w9 = wrow_slice(wrow_s, 9);

endmodule
